image_pipe_reg_slave: RTL and testbench

Register-bank slave that terminates the CPU register bus on the downstream side of the bench's register CPU interface. It decodes word-addressed accesses and holds the image-pipe control registers. It answers writes with a one-cycle write-acknowledge pulse and reads with a one-cycle read-valid pulse, each after a fixed latency. It also aggregates frame-done interrupts and drives the pipe's static configuration.

---
 rtl/image_pipe_reg_slave.sv | 203 ++++++++++++++++++++
 tb/tb_image_pipe_reg_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pipe_reg_slave.sv
// Register-bank slave for the image pipe: decodes word-addressed CPU accesses, answers with
// fixed-latency wack/rdv pulses, aggregates frame-done interrupts and drives static pipe config.
module image_pipe_reg_slave #(
    parameter int          AW         = 32,
    parameter int          DW         = 32,
    parameter int          WR_LATENCY = 1,
    parameter int          RD_LATENCY = 2,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic          reg_cpu_clk,
    input  logic          rst_n,
    input  logic          reg_cpu_cs,
    input  logic [AW-1:0] reg_cpu_addr,
    input  logic [DW-1:0] reg_cpu_data_wr,
    input  logic          reg_cpu_we,
    input  logic          reg_cpu_re,
    output logic [DW-1:0] reg_cpu_data_rd,
    output logic          reg_cpu_wack,
    output logic          reg_cpu_rdv,
    input  logic          pipe_busy,
    input  logic          frame_done,
    output logic          ctrl_enable,
    output logic          sw_rst,
    output logic [15:0]   img_width,
    output logic [15:0]   img_height,
    output logic          irq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_WAIT = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic [15:0]   width_q, width_d;
    logic [15:0]   height_q, height_d;
    logic          irq_st_q, irq_st_d;
    logic          irq_mask_q, irq_mask_d;
    logic [31:0]   scratch_q, scratch_d;
    logic          wack_q, wack_d;
    logic          rdv_q, rdv_d;
    logic [DW-1:0] data_rd_q, data_rd_d;
    logic          sw_rst_q, sw_rst_d;
    logic          irq_q, irq_d;

    logic          addr_hit;
    logic [2:0]    reg_idx;
    logic          wr_fire;
    logic [31:0]   rd_word;
    logic          unused_bits;

    assign addr_hit    = ((addr_q >> 5) == '0);
    assign reg_idx     = addr_q[4:2];
    assign unused_bits = ^{addr_q[1:0], wdata_q};

    // Read mux over the captured address; misses and unimplemented bits return 0.
    always_comb begin
        rd_word = 32'h0;
        if (addr_hit) begin
            case (reg_idx)
                3'd0:    rd_word = {31'h0, ctrl_en_q};
                3'd1:    rd_word = {30'h0, irq_q, pipe_busy};
                3'd2:    rd_word = {16'h0, width_q};
                3'd3:    rd_word = {16'h0, height_q};
                3'd4:    rd_word = {31'h0, irq_st_q};
                3'd5:    rd_word = {31'h0, irq_mask_q};
                3'd6:    rd_word = scratch_q;
                default: rd_word = VERSION;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_en_d  = ctrl_en_q;
        width_d    = width_q;
        height_d   = height_q;
        irq_st_d   = irq_st_q;
        irq_mask_d = irq_mask_q;
        scratch_d  = scratch_q;
        wack_d     = 1'b0;
        rdv_d      = 1'b0;
        data_rd_d  = '0;
        sw_rst_d   = 1'b0;
        irq_d      = irq_st_q & irq_mask_q;
        wr_fire    = 1'b0;

        // cnt_q holds the number of the upcoming edge counted from the accepting edge.
        case (state_q)
            S_IDLE: begin
                if (reg_cpu_cs && reg_cpu_we) begin
                    addr_d  = reg_cpu_addr;
                    wdata_d = reg_cpu_data_wr;
                    cnt_d   = 4'd1;
                    state_d = S_WR_WAIT;
                end else if (reg_cpu_cs && reg_cpu_re) begin
                    addr_d  = reg_cpu_addr;
                    cnt_d   = 4'd1;
                    state_d = S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == WR_LAT) begin
                    wr_fire = 1'b1;
                    wack_d  = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == RD_LAT) begin
                    rdv_d           = 1'b1;
                    data_rd_d[31:0] = rd_word;
                    state_d         = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (!reg_cpu_cs) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (wr_fire && addr_hit) begin
            case (reg_idx)
                3'd0: begin
                    ctrl_en_d = wdata_q[0];
                    sw_rst_d  = wdata_q[1];
                end
                3'd2:    width_d    = wdata_q[15:0];
                3'd3:    height_d   = wdata_q[15:0];
                3'd4:    irq_st_d   = irq_st_q & ~wdata_q[0];
                3'd5:    irq_mask_d = wdata_q[0];
                3'd6:    scratch_d  = wdata_q[31:0];
                default: ;
            endcase
        end

        // A frame completing in the same cycle as a W1C must not be lost.
        if (frame_done) begin
            irq_st_d = 1'b1;
        end
    end

    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_en_q  <= 1'b0;
            width_q    <= 16'h0;
            height_q   <= 16'h0;
            irq_st_q   <= 1'b0;
            irq_mask_q <= 1'b0;
            scratch_q  <= 32'h0;
            wack_q     <= 1'b0;
            rdv_q      <= 1'b0;
            data_rd_q  <= '0;
            sw_rst_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_en_q  <= ctrl_en_d;
            width_q    <= width_d;
            height_q   <= height_d;
            irq_st_q   <= irq_st_d;
            irq_mask_q <= irq_mask_d;
            scratch_q  <= scratch_d;
            wack_q     <= wack_d;
            rdv_q      <= rdv_d;
            data_rd_q  <= data_rd_d;
            sw_rst_q   <= sw_rst_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_cpu_data_rd = data_rd_q;
    assign reg_cpu_wack    = wack_q;
    assign reg_cpu_rdv     = rdv_q;
    assign ctrl_enable     = ctrl_en_q;
    assign sw_rst          = sw_rst_q;
    assign img_width       = width_q;
    assign img_height      = height_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_image_pipe_reg_slave.sv
// Bench for image_pipe_reg_slave: transaction-level register-map model plus directed and random accesses.
module tb_image_pipe_reg_slave;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int WR_LAT = 1;
    localparam int RD_LAT = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          cs         = 1'b0;
    logic [AW-1:0] addr       = '0;
    logic [DW-1:0] wdata      = '0;
    logic          we         = 1'b0;
    logic          re         = 1'b0;
    logic          pipe_busy  = 1'b0;
    logic          frame_done = 1'b0;
    logic [DW-1:0] data_rd;
    logic          wack;
    logic          rdv;
    logic          ctrl_enable;
    logic          sw_rst;
    logic [15:0]   img_width;
    logic [15:0]   img_height;
    logic          irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    image_pipe_reg_slave #(
        .AW(AW), .DW(DW), .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT), .VERSION(32'h0001_0000)
    ) dut (
        .reg_cpu_clk(clk), .rst_n(rst_n), .reg_cpu_cs(cs), .reg_cpu_addr(addr),
        .reg_cpu_data_wr(wdata), .reg_cpu_we(we), .reg_cpu_re(re),
        .reg_cpu_data_rd(data_rd), .reg_cpu_wack(wack), .reg_cpu_rdv(rdv),
        .pipe_busy(pipe_busy), .frame_done(frame_done), .ctrl_enable(ctrl_enable),
        .sw_rst(sw_rst), .img_width(img_width), .img_height(img_height), .irq(irq)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus the transaction scheduled for a given edge.
    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          due;
    } txn_t;

    txn_t        q[$];
    txn_t        m_t;
    int          cyc      = 0;
    bit          m_ctrl   = 0;
    bit          m_irqst  = 0;
    bit          m_mask   = 0;
    bit          m_irq    = 0;
    bit          m_nxt    = 0;
    logic [15:0] m_w      = 0;
    logic [15:0] m_h      = 0;
    logic [31:0] m_scr    = 0;
    bit          e_wack   = 0;
    bit          e_rdv    = 0;
    bit          e_swrst  = 0;
    logic [31:0] e_data   = 0;
    int          fd_cyc   = -1;
    bit          rnd_en   = 0;
    bit          pb_fixed = 0;

    function automatic bit m_hit(input logic [31:0] a);
        return (a >> 5) == 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0:    return {31'h0, m_ctrl};
            3'd1:    return {30'h0, m_irq, pipe_busy};
            3'd2:    return {16'h0, m_w};
            3'd3:    return {16'h0, m_h};
            3'd4:    return {31'h0, m_irqst};
            3'd5:    return {31'h0, m_mask};
            3'd6:    return m_scr;
            default: return 32'h0001_0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 0; m_irqst = 0; m_mask = 0; m_irq = 0;
            m_w = 0; m_h = 0; m_scr = 0;
            e_wack = 0; e_rdv = 0; e_swrst = 0; e_data = 0;
            q.delete();
        end else begin
            cyc++;
            e_wack = 0; e_rdv = 0; e_swrst = 0; e_data = 0;
            m_nxt = m_irqst & m_mask;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_t = q.pop_front();
                if (m_t.wr) begin
                    e_wack = 1;
                    if (m_hit(m_t.a)) begin
                        case (m_t.a[4:2])
                            3'd0: begin m_ctrl = m_t.d[0]; e_swrst = m_t.d[1]; end
                            3'd2: m_w = m_t.d[15:0];
                            3'd3: m_h = m_t.d[15:0];
                            3'd4: if (m_t.d[0]) m_irqst = 0;
                            3'd5: m_mask = m_t.d[0];
                            3'd6: m_scr = m_t.d;
                            default: ;
                        endcase
                    end
                end else begin
                    e_rdv  = 1;
                    e_data = m_read(m_t.a);
                end
            end
            if (frame_done) m_irqst = 1;
            m_irq = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("wack", 64'(wack), 64'(e_wack));
            chk("rdv", 64'(rdv), 64'(e_rdv));
            chk("data_rd", 64'(data_rd), 64'(e_data));
            chk("sw_rst", 64'(sw_rst), 64'(e_swrst));
            chk("ctrl_enable", 64'(ctrl_enable), 64'(m_ctrl));
            chk("img_width", 64'(img_width), 64'(m_w));
            chk("img_height", 64'(img_height), 64'(m_h));
            chk("irq", 64'(irq), 64'(m_irq));
        end
    end

    always begin
        @(posedge clk);
        #2;
        frame_done = (cyc == fd_cyc) || (rnd_en && ($urandom_range(0, 5) == 0));
        pipe_busy  = rnd_en ? 1'($urandom_range(0, 1)) : pb_fixed;
    end

    task automatic bus_xfer(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d,
                            input int extra, input bit fd, output logic [31:0] rdata, output int lat);
        int acc;
        bit seen;
        @(posedge clk);
        #1;
        cs = 1; we = wr; re = wr ? both : 1'b1; addr = a; wdata = d;
        acc = cyc + 1;
        q.push_back('{wr, a, d, acc + (wr ? WR_LAT : RD_LAT)});
        if (fd) fd_cyc = acc + WR_LAT - 1;
        seen = 0; lat = -1; rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (wr ? wack : rdv) begin
                seen  = 1;
                lat   = cyc - acc;
                rdata = data_rd[31:0];
            end
        end
        chk(wr ? "wack_seen" : "rdv_seen", 64'(seen), 64'(1));
        repeat (extra) begin
            @(posedge clk);
            #1;
        end
        cs = 0; we = 0; re = 0;
    endtask

    task automatic pulse_fd();
        @(posedge clk);
        #1;
        fd_cyc = cyc + 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        int          lat;
        int          kind;

        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        chk("reset_outs", {27'h0, wack, rdv, sw_rst, irq, ctrl_enable, img_width, img_height}, 64'h0);
        chk("reset_data_rd", 64'(data_rd), 64'h0);

        bus_xfer(0, 0, 32'h1C, 32'h0, 0, 0, rd, lat);
        chk("version_data", 64'(rd), 64'h0001_0000);
        chk("version_lat", 64'(lat), 64'd2);

        bus_xfer(1, 0, 32'h18, 32'hA5A5_5A5A, 3, 0, rd, lat);
        chk("scratch_wack_lat", 64'(lat), 64'd1);
        bus_xfer(0, 0, 32'h18, 32'h0, 0, 0, rd, lat);
        chk("scratch_readback", 64'(rd), 64'hA5A5_5A5A);

        bus_xfer(1, 0, 32'h00, 32'h3, 0, 0, rd, lat);
        chk("ctrl_enable_set", 64'(ctrl_enable), 64'd1);
        chk("sw_rst_pulse", 64'(sw_rst), 64'd1);
        @(posedge clk);
        #1;
        chk("sw_rst_cleared", 64'(sw_rst), 64'd0);
        bus_xfer(0, 0, 32'h00, 32'h0, 0, 0, rd, lat);
        chk("ctrl_readback", 64'(rd), 64'h1);

        bus_xfer(1, 0, 32'h0B, 32'h1234_0280, 0, 0, rd, lat);
        chk("img_width_set", 64'(img_width), 64'h0280);
        bus_xfer(0, 0, 32'h08, 32'h0, 0, 0, rd, lat);
        chk("img_width_readback", 64'(rd), 64'h0000_0280);

        bus_xfer(1, 0, 32'h14, 32'h1, 0, 0, rd, lat);
        pulse_fd();
        chk("irq_after_frame", 64'(irq), 64'd1);
        bus_xfer(1, 0, 32'h10, 32'h1, 0, 1, rd, lat);
        bus_xfer(0, 0, 32'h10, 32'h0, 0, 0, rd, lat);
        chk("irq_status_set_wins", 64'(rd), 64'h1);
        chk("irq_still_high", 64'(irq), 64'd1);
        bus_xfer(1, 0, 32'h10, 32'h1, 0, 0, rd, lat);
        @(posedge clk);
        #1;
        chk("irq_cleared", 64'(irq), 64'd0);

        pb_fixed = 1;
        repeat (2) @(posedge clk);
        bus_xfer(0, 0, 32'h40, 32'h0, 0, 0, rd, lat);
        chk("miss_read_zero", 64'(rd), 64'h0);
        bus_xfer(1, 0, 32'h04, 32'hFFFF_FFFF, 0, 0, rd, lat);
        bus_xfer(0, 0, 32'h04, 32'h0, 0, 0, rd, lat);
        chk("status_unchanged", 64'(rd), 64'h1);

        rnd_en = 1;
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 4));
            ra   = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(5, 31));
            bus_xfer(kind < 2, kind == 0, ra, $urandom, int'($urandom_range(0, 3)), 0, rd, lat);
        end
        rnd_en = 0;

        bus_xfer(1, 0, 32'h00, 32'h1, 0, 0, rd, lat);
        bus_xfer(1, 0, 32'h08, 32'hFFFF, 0, 0, rd, lat);
        @(posedge clk);
        #1;
        cs = 1; re = 1; addr = 32'h18;
        q.push_back('{1'b0, 32'h18, 32'h0, cyc + 1 + RD_LAT});
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midread_reset_outs", {27'h0, wack, rdv, sw_rst, irq, ctrl_enable, img_width, img_height}, 64'h0);
        chk("midread_reset_data", 64'(data_rd), 64'h0);
        cs = 0; re = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_rdv_in_reset", 64'(rdv), 64'd0);
        end
        #2 rst_n = 1;
        bus_xfer(0, 0, 32'h1C, 32'h0, 0, 0, rd, lat);
        chk("post_reset_version", 64'(rd), 64'h0001_0000);
        chk("post_reset_lat", 64'(lat), 64'd2);
        bus_xfer(0, 0, 32'h08, 32'h0, 0, 0, rd, lat);
        chk("post_reset_width", 64'(rd), 64'h0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
